// File: rtl/gf8_reduce_acc.sv
// gf8_reduce_acc: reduces 15-bit carry-less products mod POLY and XOR-accumulates them into framed GF(2^8) sums
// Ports: clk, rst_n (async, active-low); in_valid/in_ready with prod_hi/prod_lo/in_first/in_last;
//        out_valid/out_ready with out_data/out_count; seq_err pulses when a frame restarts mid-accumulation.
module gf8_reduce_acc #(
  parameter logic [7:0] POLY  = 8'h1B,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       prod_lo,
  input  logic [7:0]       prod_hi,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             seq_err
);
  logic             s1_valid, s1_first, s1_last, s1_take;
  logic [14:0]      s1_prod, red_w;
  logic [7:0]       acc, acc_n, red;
  logic [CNT_W-1:0] cnt, cnt_b, cnt_n;
  // A last term can only leave stage 1 if the output register is free or being drained.
  assign s1_take  = s1_valid && !(s1_last && out_valid && !out_ready);
  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready = rst_n && (!s1_valid || s1_take);
  // Fold x^14..x^8 down from the top so each step's spill is caught by a later step.
  always_comb begin
    red_w = s1_prod;
    for (int i = 14; i >= 8; i--)
      if (red_w[i]) red_w = red_w ^ (15'(POLY) << (i - 8)) ^ (15'd1 << i);
    red = red_w[7:0];
  end
  always_comb begin
    acc_n = (s1_first ? 8'd0 : acc) ^ red;
    cnt_b = s1_first ? '0 : cnt;
    cnt_n = &cnt_b ? cnt_b : cnt_b + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      seq_err   <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_prod  <= {prod_hi, prod_lo};
        s1_first <= in_first;
        s1_last  <= in_last;
      end else if (s1_take) begin
        s1_valid <= 1'b0;
      end
      seq_err <= s1_take && s1_first && (cnt != '0);
      if (s1_take && s1_last) begin
        out_data  <= acc_n;
        out_count <= cnt_n;
        acc       <= '0;
        cnt       <= '0;
      end else if (s1_take) begin
        acc <= acc_n;
        cnt <= cnt_n;
      end
      if (s1_take && s1_last) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/gf8_reduce_acc.md
GF8_REDUCE_ACC -- requirements
Module: gf8_reduce_acc

Interface
REQ-001 Parameter: POLY, default 8'h1B, low 8 bits of the field modulus; x^8 is implied, so the default is x^8+x^4+x^3+x+1.
REQ-002 Parameter: CNT_W, default 8, width of the term counter.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  input product is present.
REQ-006 Port: in_ready  output  1  block accepts the input this cycle.
REQ-007 Port: prod_lo  input  7  coefficients x^0..x^6 of the unreduced 15-bit carry-less product.
REQ-008 Port: prod_hi  input  8  coefficients x^7..x^14 of the same product; bit k is the coefficient of x^(k+7), matching the upstream Karatsuba high-part output.
REQ-009 Port: in_first  input  1  term starts a new accumulation.
REQ-010 Port: in_last  input  1  term closes the accumulation.
REQ-011 Port: out_valid  output  1  result is held.
REQ-012 Port: out_ready  input  1  consumer takes the result.
REQ-013 Port: out_data  output  8  reduced XOR-accumulated result.
REQ-014 Port: out_count  output  CNT_W  number of terms in the result, saturating.
REQ-015 Port: seq_err  output  1  one-cycle pulse flagging a sequencing error.

Function
REQ-016 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; the output handshake SHALL be the same with out_valid and out_ready.
REQ-017 Stage 1 SHALL register {prod_hi, prod_lo, in_first, in_last} on each transfer into s1_valid/s1_prod[14:0]/s1_first/s1_last.
REQ-018 Stage 1 SHALL advance into stage 2 (s1_take) when s1_valid=1, unless s1_last=1, out_valid=1 and out_ready=0.
REQ-019 in_ready SHALL be !s1_valid || s1_take, which gives full throughput of one term per cycle when output backpressure is absent.
REQ-020 Reduction SHALL be combinational on s1_prod.
- Process bits i = 14 down to 8.
- If bit i is 1, XOR POLY<<(i-8) and bit i itself is cleared.
- red = the remaining bits [7:0].
REQ-021 On s1_take:
- acc_n = (s1_first ? 0 : acc) ^ red.
- cnt_n = (s1_first ? 0 : cnt) + 1, saturating at 2^CNT_W-1.
REQ-022 On s1_take with s1_last=0: acc <= acc_n and cnt <= cnt_n.
REQ-023 On s1_take with s1_last=1:
- out_data <= acc_n, out_count <= cnt_n, out_valid <= 1.
- acc <= 0 and cnt <= 0.
REQ-024 in_first and in_last both 1 SHALL form a single-term accumulation.
REQ-025 An output transfer without a simultaneous s1_last take SHALL clear out_valid.
- An output transfer and a s1_last take on the same edge SHALL load the new result, and out_valid stays 1.
REQ-026 out_data and out_count SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Latency SHALL be 2 edges: a last term accepted on edge t gives out_valid=1 after edge t+1, with no backpressure.
REQ-028 seq_err SHALL pulse for exactly one cycle, registered on the take edge, when s1_first=1 is taken while cnt!=0.
- The partial sum is discarded.
- The new accumulation proceeds per REQ-021.
REQ-029 A term taken while cnt=0 and s1_first=0 SHALL accumulate onto acc=0; this is legal and raises no error.

Reset
REQ-030 While rst_n=0, the block SHALL hold all of the following at 0, asynchronously, regardless of clk:
- s1_valid, acc, cnt, out_valid, out_data, out_count, seq_err;
- in_ready, which SHALL read 1 only after rst_n deasserts.
REQ-031 Reset mid-accumulation or mid-backpressure SHALL discard all in-flight terms and results, and no output transfer SHALL occur after release until new terms arrive.

Verification
REQ-032 Single term prod_hi=0x56, prod_lo=0x79, first=last=1, out_ready=1 -> out_data=0xC1, out_count=1, out_valid exactly 2 edges after acceptance.
REQ-033 Terms (0x56,0x79, first) then (0x0B,0x09, last) on back-to-back cycles -> out_data=0xC1^0xFE=0x3F, out_count=2, in_ready held at 1.
REQ-034 Backpressure: out_ready=0 with a result held and 3 further single-term transfers offered -> the result stays stable; in_ready drops after stage 1 holds a last term; all results are delivered in order once out_ready=1.
REQ-035 Sequence error: first (0x00,0x05), then first|last (0x00,0x03) -> seq_err pulses once, out_data=0x03, out_count=1.
REQ-036 Reset pulse with rst_n=0 asserted between clock edges during an accumulation of 2 terms -> all outputs are 0 immediately; a following first|last (0x00,0x05) gives out_data=0x05, out_count=1.
REQ-037 Random regression: 10^4 random products and frame lengths 1..300 -> out_data matches the reference GF(2^8) XOR-sum, out_count saturates at 255.
